leaf_stream_buffer: RTL and testbench

LEAF_STREAM_BUFFER -- requirements
Module: leaf_stream_buffer

---
 rtl/leaf_stream_buffer.sv | 68 ++++++
 tb/tb_leaf_stream_buffer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/leaf_stream_buffer.sv
// leaf_stream_buffer: small ready/valid FIFO with occupancy, transfer count
// and synchronous flush. Storage is a plain register array (not reset).
module leaf_stream_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                xfer_cnt,
  input  logic                       flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic              live;   // clears in reset, sets on first edge after release
  logic              push, pop;

  // Handshake flags come only from registered level/live, never from inputs.
  assign in_ready  = live && (level < LW'(DEPTH));
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Storage write; contents deliberately survive reset and flush.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointers, occupancy and transfer counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      xfer_cnt <= '0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        // Power-of-two depth: pointers wrap naturally with no gap.
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr   <= rd_ptr + AW'(1);
          xfer_cnt <= xfer_cnt + 16'd1;
        end
        if (push && !pop)      level <= level + LW'(1);
        else if (pop && !push) level <= level - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_leaf_stream_buffer.sv
// Directed bench for leaf_stream_buffer with a queue scoreboard.
module tb_leaf_stream_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        level;
  logic [15:0]       xfer_cnt;

  leaf_stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .xfer_cnt(xfer_cnt), .flush(flush)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  q[$];
  logic [15:0] m_xfer = '0;
  logic        m_init = 1'b0;
  logic [15:0] x0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, scoreboard the head, update model after the edge.
  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    logic mpush, mpop;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    mpush = iv && m_init && (q.size() < DEPTH);
    mpop  = ordy && (q.size() > 0);
    #1;
    if (mpop && !fl) check("sb_data", 32'(out_data), 32'(q[0]));
    @(posedge clk); #1;
    m_init = 1'b1;
    if (fl) q.delete();
    else begin
      if (mpop) begin void'(q.pop_front()); m_xfer++; end
      if (mpush) q.push_back(d);
    end
    check("level", 32'(level), 32'(q.size()));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("xfer_cnt", 32'(xfer_cnt), 32'(m_xfer));
  endtask

  // Assert reset now, check async effect, release at a negedge, then wait one edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_level", 32'(level), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_xfer", 32'(xfer_cnt), 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    rst = 1'b0;
    q.delete(); m_xfer = '0; m_init = 1'b0;
    #1;
    check("rel_in_ready_low", 32'(in_ready), 0);
    @(posedge clk); #1;
    m_init = 1'b1;
    check("rel_in_ready_high", 32'(in_ready), 1);
    check("rel_level", 32'(level), 0);
  endtask

  initial begin
    #2;
    apply_reset();

    // S1: three pushes with downstream stalled.
    cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0);
    check("s1_level", 32'(level), 3);
    check("s1_head", 32'(out_data), 32'h11);
    check("s1_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0);

    // S2: fill, hold off an extra word, pop one.
    for (int i = 0; i < 4; i++) cyc(1, 8'hA0 + 8'(i), 0, 0);
    check("s2_full_level", 32'(level), 4);
    check("s2_full_ready", 32'(in_ready), 0);
    cyc(1, 8'hA4, 0, 0);
    check("s2_held_level", 32'(level), 4);
    cyc(1, 8'hA4, 1, 0);
    check("s2_ready_back", 32'(in_ready), 1);
    check("s2_after_pop", 32'(level), 3);
    cyc(1, 8'hA4, 0, 0);
    cyc(0, 8'h00, 1, 0); cyc(0, 8'h00, 1, 0);

    // S3: streaming at level 2.
    x0 = m_xfer;
    for (int i = 0; i < 10; i++) cyc(1, 8'hC0 + 8'(i), 1, 0);
    check("s3_level", 32'(level), 2);
    check("s3_xfer", 32'(xfer_cnt), 32'(16'(x0 + 16'd10)));

    // S4: run counter up to 0xFFFF, then wrap.
    while (m_xfer != 16'hFFFF) cyc(1, 8'(m_xfer), 1, 0);
    check("s4_ffff", 32'(xfer_cnt), 32'hFFFF);
    cyc(0, 8'h00, 1, 0);
    check("s4_wrap", 32'(xfer_cnt), 0);

    // S5: flush with a concurrent push.
    cyc(1, 8'hD0, 0, 0); cyc(1, 8'hD1, 0, 0);
    check("s5_level3", 32'(level), 3);
    cyc(1, 8'hD2, 0, 1);
    check("s5_flush_level", 32'(level), 0);
    check("s5_flush_valid", 32'(out_valid), 0);
    check("s5_flush_xfer", 32'(xfer_cnt), 0);
    cyc(1, 8'h77, 0, 0);
    check("s5_no_ghost", 32'(out_data), 32'h77);
    cyc(0, 8'h00, 1, 0);

    // S6: async reset mid-burst.
    cyc(1, 8'hE0, 0, 0); cyc(1, 8'hE1, 0, 0);
    check("s6_level2", 32'(level), 2);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hE2; out_ready = 1'b1;
    #2;
    apply_reset();
    cyc(1, 8'h5A, 0, 0);
    check("s6_first", 32'(out_data), 32'h5A);
    cyc(0, 8'h00, 1, 0);
    check("s6_empty", 32'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
